// File: rtl/rs_alu.sv
// rs_alu: reservation station with an integrated single-cycle ALU.
//
// Buffers issued ALU, branch and JALR micro-ops, wakes pending operands on
// result broadcasts (its own registered result and the load/store buffer),
// and executes the lowest-index ready entry each cycle. The result appears
// one cycle after select on rs_ready/rs_rob_id/rs_value.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   rs_full                  : occupancy >= RS_SIZE-1 (combinational)
//   clear                    : mispredict flush (qualified by rdy_in)
//   iss_*                    : issue strobe and micro-op fields
//   has_dep_n/dep_n/val_n    : per-source pending flag, tag, value
//   lsb_ready/rob_id/value   : load/store buffer broadcast
//   rs_ready/rob_id/value    : registered result broadcast
module rs_alu #(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic                 rs_full,
    input  logic                 clear,
    input  logic                 iss_valid,
    input  logic [ROB_WIDTH-1:0] iss_rob_id,
    input  logic [4:0]           iss_op,
    input  logic                 iss_use_imm,
    input  logic [31:0]          iss_imm,
    input  logic [31:0]          iss_pc,
    input  logic                 has_dep_1,
    input  logic                 has_dep_2,
    input  logic [ROB_WIDTH-1:0] dep_1,
    input  logic [ROB_WIDTH-1:0] dep_2,
    input  logic [31:0]          val_1,
    input  logic [31:0]          val_2,
    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    output logic                 rs_ready,
    output logic [ROB_WIDTH-1:0] rs_rob_id,
    output logic [31:0]          rs_value
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_SLT  = 5'd8,
        OP_SLTU = 5'd9,
        OP_BEQ  = 5'd16,
        OP_BNE  = 5'd17,
        OP_BLT  = 5'd18,
        OP_BGE  = 5'd19,
        OP_BLTU = 5'd20,
        OP_BGEU = 5'd21,
        OP_JALR = 5'd24
    } op_e;

    // Entry storage
    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   use_imm_q;
    logic [RS_SIZE-1:0]   q1;
    logic [RS_SIZE-1:0]   q2;
    op_e                  op_q   [RS_SIZE];
    logic [31:0]          imm_q  [RS_SIZE];
    logic [31:0]          pc_q   [RS_SIZE];
    logic [31:0]          v1_q   [RS_SIZE];
    logic [31:0]          v2_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_q  [RS_SIZE];
    logic [ROB_WIDTH-1:0] t1_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] t2_q   [RS_SIZE];

    // Occupancy, free slot and select
    logic [CNT_W-1:0] occ;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;

    always_comb begin
        occ        = '0;
        free_idx   = '0;
        free_found = 1'b0;
        sel_idx    = '0;
        sel_found  = 1'b0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            occ = occ + CNT_W'(busy[i]);
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i] && !q1[i] && !q2[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign rs_full = (occ >= CNT_W'(RS_SIZE - 1));

    // Issue-time operand resolution: a same-cycle broadcast of the
    // producing tag is captured directly; the own result wins over lsb.
    logic        iss_q1;
    logic        iss_q2;
    logic [31:0] iss_v1;
    logic [31:0] iss_v2;

    always_comb begin
        iss_q1 = has_dep_1;
        iss_v1 = val_1;
        if (has_dep_1) begin
            if (rs_ready && rs_rob_id == dep_1) begin
                iss_q1 = 1'b0;
                iss_v1 = rs_value;
            end else if (lsb_ready && lsb_rob_id == dep_1) begin
                iss_q1 = 1'b0;
                iss_v1 = lsb_value;
            end
        end

        // An immediate operand 2 never waits on a producer
        iss_q2 = has_dep_2 && !iss_use_imm;
        iss_v2 = val_2;
        if (iss_q2) begin
            if (rs_ready && rs_rob_id == dep_2) begin
                iss_q2 = 1'b0;
                iss_v2 = rs_value;
            end else if (lsb_ready && lsb_rob_id == dep_2) begin
                iss_q2 = 1'b0;
                iss_v2 = lsb_value;
            end
        end
    end

    // ALU on the selected entry
    op_e         sel_op;
    logic [31:0] opa;
    logic [31:0] opv2;
    logic [31:0] opb;
    logic [31:0] sel_imm;
    logic [31:0] sel_pc;
    logic [4:0]  shamt;
    logic        taken;
    logic [31:0] alu_res;

    always_comb begin
        sel_op  = op_q[sel_idx];
        opa     = v1_q[sel_idx];
        opv2    = v2_q[sel_idx];
        sel_imm = imm_q[sel_idx];
        sel_pc  = pc_q[sel_idx];
        opb     = use_imm_q[sel_idx] ? sel_imm : opv2;
        shamt   = opb[4:0];

        // Branches always compare the two register operands
        taken = 1'b0;
        case (sel_op)
            OP_BEQ:  taken = (opa == opv2);
            OP_BNE:  taken = (opa != opv2);
            OP_BLT:  taken = ($signed(opa) <  $signed(opv2));
            OP_BGE:  taken = ($signed(opa) >= $signed(opv2));
            OP_BLTU: taken = (opa <  opv2);
            OP_BGEU: taken = (opa >= opv2);
            default: taken = 1'b0;
        endcase

        alu_res = '0;
        case (sel_op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SLL:  alu_res = opa << shamt;
            OP_SRL:  alu_res = opa >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
            OP_SLT:  alu_res = {31'd0, $signed(opa) < $signed(opb)};
            OP_SLTU: alu_res = {31'd0, opa < opb};
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                     alu_res = taken ? (sel_pc + sel_imm) : (sel_pc + 32'd4);
            OP_JALR: alu_res = (opa + sel_imm) & ~32'd1;
            default: alu_res = '0;
        endcase
    end

    // State update. Wake-up only touches busy entries and allocation only
    // a non-busy one, so the two never collide on the same slot; the slot
    // freed by select is busy at cycle start and so is not reallocated.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy      <= '0;
            use_imm_q <= '0;
            q1        <= '0;
            q2        <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= OP_ADD;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                rob_q[i] <= '0;
                t1_q[i]  <= '0;
                t2_q[i]  <= '0;
            end
            rs_ready  <= 1'b0;
            rs_rob_id <= '0;
            rs_value  <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                busy     <= '0;
                rs_ready <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && q1[i]) begin
                        if (rs_ready && rs_rob_id == t1_q[i]) begin
                            q1[i]   <= 1'b0;
                            v1_q[i] <= rs_value;
                        end else if (lsb_ready && lsb_rob_id == t1_q[i]) begin
                            q1[i]   <= 1'b0;
                            v1_q[i] <= lsb_value;
                        end
                    end
                    if (busy[i] && q2[i]) begin
                        if (rs_ready && rs_rob_id == t2_q[i]) begin
                            q2[i]   <= 1'b0;
                            v2_q[i] <= rs_value;
                        end else if (lsb_ready && lsb_rob_id == t2_q[i]) begin
                            q2[i]   <= 1'b0;
                            v2_q[i] <= lsb_value;
                        end
                    end
                end

                rs_ready <= sel_found;
                if (sel_found) begin
                    busy[sel_idx] <= 1'b0;
                    rs_rob_id     <= rob_q[sel_idx];
                    rs_value      <= alu_res;
                end

                if (iss_valid && free_found) begin
                    busy[free_idx]      <= 1'b1;
                    op_q[free_idx]      <= op_e'(iss_op);
                    use_imm_q[free_idx] <= iss_use_imm;
                    imm_q[free_idx]     <= iss_imm;
                    pc_q[free_idx]      <= iss_pc;
                    rob_q[free_idx]     <= iss_rob_id;
                    q1[free_idx]        <= iss_q1;
                    q2[free_idx]        <= iss_q2;
                    t1_q[free_idx]      <= dep_1;
                    t2_q[free_idx]      <= dep_2;
                    v1_q[free_idx]      <= iss_v1;
                    v2_q[free_idx]      <= iss_v2;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed scenarios plus randomized traffic for rs_alu.
// Expected results go into a tag-keyed scoreboard at issue time; a monitor
// retires them when the DUT broadcasts. Inputs change 1 unit after posedge,
// outputs are sampled at negedge.
module tb_rs_alu;

    localparam int unsigned RS_SIZE   = 8;
    localparam int unsigned ROB_WIDTH = 4;

    logic                 clk_in;
    logic                 rst_in;
    logic                 rdy_in;
    logic                 rs_full;
    logic                 clear;
    logic                 iss_valid;
    logic [ROB_WIDTH-1:0] iss_rob_id;
    logic [4:0]           iss_op;
    logic                 iss_use_imm;
    logic [31:0]          iss_imm;
    logic [31:0]          iss_pc;
    logic                 has_dep_1;
    logic                 has_dep_2;
    logic [ROB_WIDTH-1:0] dep_1;
    logic [ROB_WIDTH-1:0] dep_2;
    logic [31:0]          val_1;
    logic [31:0]          val_2;
    logic                 lsb_ready;
    logic [ROB_WIDTH-1:0] lsb_rob_id;
    logic [31:0]          lsb_value;
    logic                 rs_ready;
    logic [ROB_WIDTH-1:0] rs_rob_id;
    logic [31:0]          rs_value;

    rs_alu #(.RS_SIZE(RS_SIZE), .ROB_WIDTH(ROB_WIDTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rs_full(rs_full),
        .clear(clear), .iss_valid(iss_valid), .iss_rob_id(iss_rob_id),
        .iss_op(iss_op), .iss_use_imm(iss_use_imm), .iss_imm(iss_imm),
        .iss_pc(iss_pc), .has_dep_1(has_dep_1), .has_dep_2(has_dep_2),
        .dep_1(dep_1), .dep_2(dep_2), .val_1(val_1), .val_2(val_2),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        tag_live [16];
    logic        tag_used [16];
    logic [31:0] model_val[16];
    logic        lsb_pend [16];
    logic [31:0] lsb_val  [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        lsb_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
        tag_live[tag]  = 1'b1;
        tag_used[tag]  = 1'b1;
        model_val[tag] = val;
    endtask

    task automatic drive_issue(input logic [3:0] tag, input logic [4:0] op,
                               input logic ui, input logic [31:0] imm, input logic [31:0] pc,
                               input logic hd1, input logic [3:0] d1, input logic [31:0] v1,
                               input logic hd2, input logic [3:0] d2, input logic [31:0] v2);
        iss_valid   = 1'b1;
        iss_rob_id  = tag;
        iss_op      = op;
        iss_use_imm = ui;
        iss_imm     = imm;
        iss_pc      = pc;
        has_dep_1   = hd1;
        dep_1       = d1;
        val_1       = v1;
        has_dep_2   = hd2;
        dep_2       = d2;
        val_2       = v2;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d outstanding results expected 0", sb.size());
        end
    endtask

    // Reference semantics of every operation, straight from the op table
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] v2, input logic [31:0] imm,
                                              input logic [31:0] pc, input logic ui);
        logic [31:0] b;
        int unsigned sh;
        logic        tk;
        b  = ui ? imm : v2;
        sh = b % 32;
        tk = 1'b0;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << sh;
            5'd6:  return a >> sh;
            5'd7:  return $unsigned($signed(a) >>> sh);
            5'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21: begin
                case (op)
                    5'd16:   tk = (a == v2);
                    5'd17:   tk = (a != v2);
                    5'd18:   tk = ($signed(a) < $signed(v2));
                    5'd19:   tk = ($signed(a) >= $signed(v2));
                    5'd20:   tk = (a < v2);
                    default: tk = (a >= v2);
                endcase
                return tk ? pc + imm : pc + 32'd4;
            end
            5'd24: return (a + imm) & 32'hFFFF_FFFE;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // Pick a source operand: literal, RS producer or load/store producer
    task automatic gen_src(input int bc, output logic hd, output logic [3:0] d,
                           output logic [31:0] drv, output logic [31:0] val);
        int unsigned mode;
        int unsigned p;
        hd   = 1'b0;
        d    = 4'($urandom_range(0, 15));
        drv  = rnd_val();
        val  = drv;
        mode = $urandom_range(0, 2);
        if (mode == 1) begin
            p = $urandom_range(0, 7);
            if (tag_used[p]) begin
                val = model_val[p];
                if (tag_live[p]) begin
                    hd  = 1'b1;
                    d   = 4'(p);
                    drv = $urandom;
                end else begin
                    drv = model_val[p];
                end
            end
        end else if (mode == 2) begin
            p = 8 + $urandom_range(0, 7);
            if (int'(p) != bc && !lsb_pend[p]) begin
                lsb_val[p]  = rnd_val();
                lsb_pend[p] = 1'b1;
            end
            hd  = 1'b1;
            d   = 4'(p);
            drv = $urandom;
            val = lsb_val[p];
        end
    endtask

    // Scoreboard monitor: one retirement per enabled cycle with rs_ready
    initial begin
        int idx;
        forever begin
            @(negedge clk_in);
            if (!rst_in && rdy_in && rs_ready) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].tag == rs_rob_id) idx = i;
                if (idx < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got tag %0d value 0x%08h expected no broadcast",
                             rs_rob_id, rs_value);
                end else begin
                    chk($sformatf("sb_tag%0d", rs_rob_id), rs_value, sb[idx].val);
                    tag_live[rs_rob_id] = 1'b0;
                    sb.delete(idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ops[19];
        logic        hd1, hd2, ui;
        logic [3:0]  d1, d2, t;
        logic [31:0] drv1, drv2, a, v2, imm, pc;
        logic [4:0]  op;
        int          bc;
        int unsigned s;
        logic        found;

        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd24, 5'd12, 5'd30};
        for (int i = 0; i < 16; i++) begin
            tag_live[i] = 1'b0; tag_used[i] = 1'b0; model_val[i] = '0;
            lsb_pend[i] = 1'b0; lsb_val[i]  = '0;
        end
        idle();
        drive_issue(4'd0, 5'd0, 1'b0, '0, '0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0);
        iss_valid  = 1'b0;
        lsb_rob_id = '0;
        lsb_value  = '0;
        rdy_in     = 1'b1;
        rst_in     = 1'b1;
        tick(); tick();
        chk("reset_ready", rs_ready, 0);
        chk("reset_rob_id", rs_rob_id, 0);
        chk("reset_value", rs_value, 0);
        chk("reset_full", rs_full, 0);
        rst_in = 1'b0;

        // ADD 5+7, tag 3: result two edges after issue, single cycle wide
        drive_issue(4'd3, 5'd0, 1'b0, '0, '0, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
        push_exp(4'd3, 32'd12);
        tick(); idle();
        chk("add_not_in_issue_cycle", rs_ready, 0);
        tick();
        chk("add_ready", rs_ready, 1);
        chk("add_rob_id", rs_rob_id, 3);
        chk("add_value", rs_value, 12);
        tick();
        chk("add_ready_drop", rs_ready, 0);

        // Back-to-back dependency through the own broadcast
        drive_issue(4'd1, 5'd1, 1'b0, '0, '0, 1'b0, 4'd0, 32'd10, 1'b0, 4'd0, 32'd3);
        push_exp(4'd1, 32'd7);
        tick();
        drive_issue(4'd2, 5'd0, 1'b1, 32'd100, '0, 1'b1, 4'd1, 32'hDEAD_BEEF, 1'b0, 4'd0, '0);
        push_exp(4'd2, 32'd107);
        tick(); idle();
        chk("dep_producer_id", rs_rob_id, 1);
        chk("dep_producer_value", rs_value, 7);
        tick();
        chk("dep_gap_cycle", rs_ready, 0);
        tick();
        chk("dep_consumer_ready", rs_ready, 1);
        chk("dep_consumer_id", rs_rob_id, 2);
        chk("dep_consumer_value", rs_value, 107);

        // Issue-time capture of a same-cycle lsb broadcast
        drive_issue(4'd4, 5'd7, 1'b1, 32'd4, '0, 1'b1, 4'd6, 32'd0, 1'b1, 4'd9, '0);
        lsb_ready = 1'b1; lsb_rob_id = 4'd6; lsb_value = 32'hFFFF_FFFF;
        push_exp(4'd4, 32'hFFFF_FFFF);
        tick(); idle();
        tick();
        chk("lsb_issue_wake_ready", rs_ready, 1);
        chk("lsb_issue_wake_id", rs_rob_id, 4);

        // Branches and JALR
        drive_issue(4'd5, 5'd18, 1'b0, 32'h20, 32'h100, 1'b0, 4'd0, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd1);
        push_exp(4'd5, 32'h120);
        tick();
        drive_issue(4'd6, 5'd20, 1'b0, 32'h20, 32'h100, 1'b0, 4'd0, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd1);
        push_exp(4'd6, 32'h104);
        tick();
        drive_issue(4'd7, 5'd24, 1'b1, 32'h0, 32'h100, 1'b0, 4'd0, 32'h203, 1'b0, 4'd0, 32'd0);
        push_exp(4'd7, 32'h202);
        tick(); idle();
        drain(50);

        // Fill with entries waiting on tag 15, then flush
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            drive_issue(4'(i), 5'd0, 1'b0, '0, '0, 1'b1, 4'd15, '0, 1'b0, 4'd0, 32'd1);
            tick();
            if (i == int'(RS_SIZE) - 3) chk("full_below_threshold", rs_full, 0);
            if (i == int'(RS_SIZE) - 2) chk("full_at_threshold", rs_full, 1);
        end
        idle();
        chk("full_all_busy", rs_full, 1);
        clear = 1'b1;
        tick(); idle();
        chk("clear_ready", rs_ready, 0);
        chk("clear_full", rs_full, 0);
        lsb_ready = 1'b1; lsb_rob_id = 4'd15; lsb_value = 32'd1;
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clear_no_wake", rs_ready, 0);
        end
        // Issue presented together with clear is dropped
        drive_issue(4'd3, 5'd0, 1'b0, '0, '0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
        clear = 1'b1;
        tick(); idle();
        tick();
        chk("clear_drops_issue_a", rs_ready, 0);
        tick();
        chk("clear_drops_issue_b", rs_ready, 0);

        // rdy_in low freezes a pending broadcast
        drive_issue(4'd5, 5'd0, 1'b0, '0, '0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
        push_exp(4'd5, 32'd3);
        tick(); idle();
        tick();
        chk("hold_start_ready", rs_ready, 1);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ready", rs_ready, 1);
            chk("hold_rob_id", rs_rob_id, 5);
            chk("hold_value", rs_value, 3);
        end
        rdy_in = 1'b1;
        tick();
        chk("hold_release", rs_ready, 0);

        // Reset mid-operation discards the entry before it broadcasts
        drive_issue(4'd2, 5'd0, 1'b0, '0, '0, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd4);
        tick(); idle();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("midreset_ready", rs_ready, 0);
        tick();
        chk("midreset_no_result", rs_ready, 0);

        // Randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            bc = -1;
            if (rdy_in && $urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, 7);
                for (int k = 0; k < 8 && bc < 0; k++) begin
                    if (lsb_pend[8 + ((s + k) % 8)]) bc = 8 + int'((s + k) % 8);
                end
                if (bc >= 0) begin
                    lsb_ready   = 1'b1;
                    lsb_rob_id  = 4'(bc);
                    lsb_value   = lsb_val[bc];
                    lsb_pend[bc] = 1'b0;
                end
            end
            if (rdy_in && !rs_full && $urandom_range(0, 3) != 0) begin
                found = 1'b0;
                t = '0;
                s = $urandom_range(0, 7);
                for (int k = 0; k < 8; k++) begin
                    if (!found && !tag_live[(s + k) % 8]) begin
                        found = 1'b1;
                        t = 4'((s + k) % 8);
                    end
                end
                if (found) begin
                    op  = ops[$urandom_range(0, 18)];
                    imm = rnd_val();
                    pc  = $urandom & 32'hFFFF_FFFC;
                    ui  = (op == 5'd24) ? 1'b1 : (op >= 5'd16) ? 1'b0 : 1'($urandom_range(0, 1));
                    gen_src(bc, hd1, d1, drv1, a);
                    if (ui) begin
                        hd2  = 1'($urandom_range(0, 1));
                        d2   = 4'd14;
                        drv2 = $urandom;
                        v2   = drv2;
                    end else begin
                        gen_src(bc, hd2, d2, drv2, v2);
                    end
                    drive_issue(t, op, ui, imm, pc, hd1, d1, drv1, hd2, d2, drv2);
                    push_exp(t, ref_model(op, a, v2, imm, pc, ui));
                end
            end
            tick();
        end
        idle();
        rdy_in = 1'b1;
        for (int p = 8; p < 16; p++) begin
            if (lsb_pend[p]) begin
                lsb_ready  = 1'b1;
                lsb_rob_id = 4'(p);
                lsb_value  = lsb_val[p];
                lsb_pend[p] = 1'b0;
                tick();
                lsb_ready = 1'b0;
            end
        end
        drain(200);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
